// File: rtl/point_op_pkg.sv
// Shared encodings for the point-operation engine: operation modes, FSM states
// and the source BRAM read latency that sets the pipeline depth.
package point_op_pkg;

    localparam int READ_LATENCY = 1;
    localparam int STAGES       = READ_LATENCY + 1;

    typedef enum logic [1:0] {
        MODE_COPY   = 2'd0,
        MODE_ADD    = 2'd1,
        MODE_SUB    = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/point_op_alu.sv
// Combinational per-pixel point operation: copy, saturating add, floored
// subtract, or binary threshold to 0 / max.
module point_op_alu
    import point_op_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] pixel,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MAX = '1;

    // One extra bit so the carry out flags saturation.
    logic [DATA_W:0] sum;
    assign sum = {1'b0, pixel} + {1'b0, offset};

    always_comb begin
        result = pixel;
        case (mode_e'(mode))
            MODE_COPY:   result = pixel;
            MODE_ADD:    result = sum[DATA_W] ? MAX : sum[DATA_W-1:0];
            MODE_SUB:    result = (pixel >= offset) ? (pixel - offset) : '0;
            MODE_THRESH: result = (pixel >= threshold) ? MAX : '0;
            default:     result = pixel;
        endcase
    end

endmodule

// File: rtl/point_op_engine.sv
// Streams a source BRAM through a point operation into a destination BRAM:
// one read per cycle, each write lands READ_LATENCY+1 cycles after its read.
module point_op_engine
    import point_op_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 17,
    parameter int NUM_PIXELS = 65536
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] threshold,
    output logic              busy,
    output logic              done,
    output logic              src_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              dst_en,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] addr_d1;
    logic [STAGES:1]   vld_pipe;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] offset_q, threshold_q;
    logic [DATA_W-1:0] alu_out;
    logic              issue, last_rd;

    assign issue   = (state == ST_RUN);
    assign last_rd = (rd_cnt == LAST_ADDR);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (last_rd) state_nx = ST_DRAIN;
            // Leave once the final write is on the port and nothing is behind it.
            ST_DRAIN: if (vld_pipe[STAGES] && (vld_pipe[STAGES-1:1] == '0)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            rd_cnt      <= '0;
            addr_d1     <= '0;
            vld_pipe    <= '0;
            mode_q      <= '0;
            offset_q    <= '0;
            threshold_q <= '0;
            dst_addr    <= '0;
            dst_data    <= '0;
        end else begin
            state    <= state_nx;
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            if (state == ST_IDLE && start) begin
                mode_q      <= mode;
                offset_q    <= offset;
                threshold_q <= threshold;
            end
            // Counter parks at 0 between runs so src_addr idles low.
            if (issue) begin
                rd_cnt  <= last_rd ? '0 : rd_cnt + 1'b1;
                addr_d1 <= rd_cnt;
            end
            if (vld_pipe[1]) begin
                dst_addr <= addr_d1;
                dst_data <= alu_out;
            end
        end
    end

    point_op_alu #(.DATA_W(DATA_W)) u_alu (
        .pixel     (src_data),
        .mode      (mode_q),
        .offset    (offset_q),
        .threshold (threshold_q),
        .result    (alu_out)
    );

    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign src_en   = issue;
    assign src_addr = rd_cnt;
    assign dst_en   = vld_pipe[STAGES];
    assign dst_we   = vld_pipe[STAGES];

endmodule

// File: tb/tb_point_op_engine.sv
// Directed bench: three engines (4, 1 and 8 pixels) with behavioural source
// BRAMs; table-driven mode vectors plus hand-written run/abort sequences.
module tb_point_op_engine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [1:0] mode;
    logic [7:0] offset, threshold;
    logic       start_a, start_b, start_c;

    logic        busy_a, done_a, src_en_a, dst_en_a, dst_we_a;
    logic [16:0] src_addr_a, dst_addr_a;
    logic [7:0]  src_data_a, dst_data_a;
    logic        busy_b, done_b, src_en_b, dst_en_b, dst_we_b;
    logic [16:0] src_addr_b, dst_addr_b;
    logic [7:0]  src_data_b, dst_data_b;
    logic        busy_c, done_c, src_en_c, dst_en_c, dst_we_c;
    logic [16:0] src_addr_c, dst_addr_c;
    logic [7:0]  src_data_c, dst_data_c;

    logic [7:0] mem_a [4];
    logic [7:0] mem_b [1];
    logic [7:0] mem_c [8];

    always @(posedge clock) if (src_en_a) src_data_a <= mem_a[src_addr_a[1:0]];
    always @(posedge clock) if (src_en_b) src_data_b <= mem_b[0];
    always @(posedge clock) if (src_en_c) src_data_c <= mem_c[src_addr_c[2:0]];

    point_op_engine #(.DATA_W(8), .ADDR_W(17), .NUM_PIXELS(4)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .mode(mode), .offset(offset),
        .threshold(threshold), .busy(busy_a), .done(done_a), .src_en(src_en_a),
        .src_addr(src_addr_a), .src_data(src_data_a), .dst_en(dst_en_a), .dst_we(dst_we_a),
        .dst_addr(dst_addr_a), .dst_data(dst_data_a));

    point_op_engine #(.DATA_W(8), .ADDR_W(17), .NUM_PIXELS(1)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .mode(mode), .offset(offset),
        .threshold(threshold), .busy(busy_b), .done(done_b), .src_en(src_en_b),
        .src_addr(src_addr_b), .src_data(src_data_b), .dst_en(dst_en_b), .dst_we(dst_we_b),
        .dst_addr(dst_addr_b), .dst_data(dst_data_b));

    point_op_engine #(.DATA_W(8), .ADDR_W(17), .NUM_PIXELS(8)) dut_c (
        .clock(clock), .reset(reset), .start(start_c), .mode(mode), .offset(offset),
        .threshold(threshold), .busy(busy_c), .done(done_c), .src_en(src_en_c),
        .src_addr(src_addr_c), .src_data(src_data_c), .dst_en(dst_en_c), .dst_we(dst_we_c),
        .dst_addr(dst_addr_c), .dst_data(dst_data_c));

    // Write log for engine c, sampled mid-cycle.
    int          wr_cnt_c = 0;
    logic [16:0] wr_addr_c [64];
    logic [7:0]  wr_data_c [64];
    always @(negedge clock) begin
        if (dst_en_c === 1'b1) begin
            wr_addr_c[wr_cnt_c % 64] = dst_addr_c;
            wr_data_c[wr_cnt_c % 64] = dst_data_c;
            wr_cnt_c = wr_cnt_c + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]      mode;
        logic [7:0]      off;
        logic [7:0]      thr;
        logic [3:0][7:0] src;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    // One 4-pixel run on engine a; ports are scrambled right after the latch.
    task automatic run_a(input int v);
        int idx;
        for (int i = 0; i < 4; i++) mem_a[i] = vecs[v].src[i];
        mode      = vecs[v].mode;
        offset    = vecs[v].off;
        threshold = vecs[v].thr;
        start_a   = 1'b1;
        @(posedge clock); #1;
        start_a   = 1'b0;
        mode      = ~vecs[v].mode;
        offset    = ~vecs[v].off;
        threshold = ~vecs[v].thr;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk($sformatf("v%0d c%0d busy", v, c), busy_a, (c <= 5));
            chk($sformatf("v%0d c%0d done", v, c), done_a, (c == 6));
            chk($sformatf("v%0d c%0d src_en", v, c), src_en_a, (c <= 3));
            if (c <= 3) chk($sformatf("v%0d c%0d src_addr", v, c), src_addr_a, c);
            chk($sformatf("v%0d c%0d dst_en", v, c), dst_en_a, (c >= 2 && c <= 5));
            chk($sformatf("v%0d c%0d dst_we", v, c), dst_we_a, (c >= 2 && c <= 5));
            if (c >= 2) begin
                idx = (c - 2 > 3) ? 3 : c - 2;
                chk($sformatf("v%0d c%0d dst_addr", v, c), dst_addr_a, idx);
                chk($sformatf("v%0d c%0d dst_data", v, c), dst_data_a, vecs[v].exp[idx]);
            end
        end
    endtask

    initial begin
        int base, done_at;
        logic stray;

        vecs[0] = '{mode:2'd0, off:8'd0,   thr:8'd0,
                    src:{8'd40, 8'd30, 8'd20, 8'd10},  exp:{8'd40, 8'd30, 8'd20, 8'd10}};
        vecs[1] = '{mode:2'd1, off:8'd10,  thr:8'd0,
                    src:{8'd255, 8'd250, 8'd245, 8'd0}, exp:{8'd255, 8'd255, 8'd255, 8'd10}};
        vecs[2] = '{mode:2'd2, off:8'd10,  thr:8'd0,
                    src:{8'd200, 8'd11, 8'd10, 8'd5},   exp:{8'd190, 8'd1, 8'd0, 8'd0}};
        vecs[3] = '{mode:2'd3, off:8'd0,   thr:8'd128,
                    src:{8'd255, 8'd128, 8'd127, 8'd0}, exp:{8'd255, 8'd255, 8'd0, 8'd0}};
        vecs[4] = '{mode:2'd1, off:8'd255, thr:8'd0,
                    src:{8'd255, 8'd100, 8'd1, 8'd0},   exp:{8'd255, 8'd255, 8'd255, 8'd255}};
        vecs[5] = '{mode:2'd3, off:8'd0,   thr:8'd0,
                    src:{8'd3, 8'd2, 8'd1, 8'd0},       exp:{8'd255, 8'd255, 8'd255, 8'd255}};

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode = 2'd0; offset = 8'd0; threshold = 8'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst busy",     {busy_a, busy_b, busy_c}, 0);
        chk("rst done",     {done_a, done_b, done_c}, 0);
        chk("rst src_en",   {src_en_a, src_en_b, src_en_c}, 0);
        chk("rst dst_en",   {dst_en_a, dst_en_b, dst_en_c, dst_we_a, dst_we_b, dst_we_c}, 0);
        chk("rst src_addr", src_addr_a | src_addr_b | src_addr_c, 0);
        chk("rst dst_addr", dst_addr_a | dst_addr_b | dst_addr_c, 0);
        chk("rst dst_data", {dst_data_a, dst_data_b, dst_data_c}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        for (int v = 0; v < 6; v++) run_a(v);

        // Single-pixel run; start and mode poked while busy and in DONE.
        mem_b[0] = 8'd100;
        mode = 2'd1; offset = 8'd10; threshold = 8'd50;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        @(negedge clock);
        chk("np1 c0 busy", busy_b, 1);
        chk("np1 c0 src_en", src_en_b, 1);
        chk("np1 c0 src_addr", src_addr_b, 0);
        chk("np1 c0 dst_en", dst_en_b, 0);
        @(posedge clock); #1;
        start_b = 1'b1; mode = 2'd3; threshold = 8'd0;
        @(negedge clock);
        chk("np1 c1 busy", busy_b, 1);
        chk("np1 c1 src_en", src_en_b, 0);
        chk("np1 c1 dst_en", dst_en_b, 0);
        @(negedge clock);
        chk("np1 c2 busy", busy_b, 1);
        chk("np1 c2 dst_en", dst_en_b, 1);
        chk("np1 c2 dst_addr", dst_addr_b, 0);
        chk("np1 c2 dst_data", dst_data_b, 110);
        @(negedge clock);
        chk("np1 c3 done", done_b, 1);
        chk("np1 c3 busy", busy_b, 0);
        chk("np1 c3 dst_en", dst_en_b, 0);
        @(posedge clock); #1;
        start_b = 1'b0;
        stray = 1'b0;
        for (int c = 4; c < 10; c++) begin
            @(negedge clock);
            if (busy_b || done_b || src_en_b || dst_en_b) stray = 1'b1;
        end
        chk("np1 no second run", stray, 0);
        chk("np1 dst_data held", dst_data_b, 110);

        // Eight-pixel run aborted by reset in cycle 4.
        for (int i = 0; i < 8; i++) mem_c[i] = 8'(i + 1);
        mode = 2'd0; offset = 8'd0; threshold = 8'd0;
        base = wr_cnt_c;
        start_c = 1'b1;
        @(posedge clock); #1;
        start_c = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("abort busy", busy_c, 0);
        chk("abort done", done_c, 0);
        chk("abort src", {src_en_c, src_addr_c}, 0);
        chk("abort dst_en", {dst_en_c, dst_we_c}, 0);
        chk("abort dst_addr", dst_addr_c, 0);
        chk("abort dst_data", dst_data_c, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done_c || busy_c || dst_en_c || src_en_c) stray = 1'b1;
        end
        chk("abort quiet", stray, 0);
        chk("abort write count", wr_cnt_c - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort wr%0d addr", i), wr_addr_c[(base + i) % 64], i);
            chk($sformatf("abort wr%0d data", i), wr_data_c[(base + i) % 64], i + 1);
        end

        // Clean rerun from address 0.
        base = wr_cnt_c;
        done_at = -1;
        start_c = 1'b1;
        @(posedge clock); #1;
        start_c = 1'b0;
        for (int c = 0; c < 30 && done_at < 0; c++) begin
            @(negedge clock);
            if (done_c) done_at = c;
        end
        chk("rerun done cycle", done_at, 10);
        chk("rerun write count", wr_cnt_c - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rerun wr%0d addr", i), wr_addr_c[(base + i) % 64], i);
            chk($sformatf("rerun wr%0d data", i), wr_data_c[(base + i) % 64], i + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/point_op_engine.md
Name: point_op_engine

Overview:
Downstream consumer of the image BRAM. On a start pulse it scans a source BRAM linearly from address 0, applies a per-pixel point operation (copy, brightening, darkening or binary threshold) and writes each result to the same address in a destination BRAM. It is fully pipelined: one read is issued every cycle, and each write follows its read by a fixed 2 cycles. It drives both BRAM port sets directly and accounts for the BRAM's 1-cycle registered read latency.

Parameters:
DATA_W, 8, pixel width in bits; max pixel value is 2**DATA_W-1.
ADDR_W, 17, BRAM address width.
NUM_PIXELS, 65536, number of pixels processed per run; range 1..2**ADDR_W.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  1-cycle request; accepted only when busy=0.
mode  in  2  operation: 0 copy, 1 add offset (saturating), 2 subtract offset (floor at 0), 3 threshold.
offset  in  DATA_W  operand for modes 1 and 2.
threshold  in  DATA_W  operand for mode 3.
busy  out  1  high from the cycle after start is accepted through the final write cycle.
done  out  1  1-cycle pulse in the cycle after the final write.
src_en  out  1  source BRAM ram_enable; read-only, no write enable is driven.
src_addr  out  ADDR_W  source read address.
src_data  in  DATA_W  source BRAM output_data; valid 1 cycle after src_en.
dst_en  out  1  destination ram_enable.
dst_we  out  1  destination write_enable; always equal to dst_en.
dst_addr  out  ADDR_W  destination address.
dst_data  out  DATA_W  destination input_data.

Behaviour:
- Reset: state IDLE. busy, done, src_en, dst_en and dst_we are 0. src_addr, dst_addr and dst_data are 0. All pipeline valid bits and counters are cleared.
- Reset mid-run takes effect on the next edge. The engine stops immediately; any in-flight write is discarded and no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1, latch mode, offset and threshold, then go to RUN. Port changes after the latch have no effect until the next run.
- RUN, cycle k (k = 0..NUM_PIXELS-1): src_en=1, src_addr=k. After issuing NUM_PIXELS-1, go to DRAIN.
- Pipeline: a read issued in cycle k returns src_data in cycle k+1. The result is computed combinationally and registered, so in cycle k+2: dst_en=dst_we=1, dst_addr=k, dst_data=f(pixel k).
- DRAIN: src_en=0. Stay until the last write (cycle NUM_PIXELS+1) has been driven, then go to DONE.
- DONE: a single cycle with done=1 and busy=0, then IDLE.
- Overall: a run takes NUM_PIXELS+2 busy cycles, and done occurs at cycle NUM_PIXELS+2 counted from the first RUN cycle.
- start while busy or in DONE is ignored and is not queued.
- Function f, evaluated at width DATA_W+1 to detect overflow:
  - mode 0: p.
  - mode 1: min(p+offset, MAX).
  - mode 2: p>=offset ? p-offset : 0.
  - mode 3: p>=threshold ? MAX : 0.
- Addresses never wrap. The read counter stops at NUM_PIXELS-1. Address 2**ADDR_W-1 is legal when NUM_PIXELS=2**ADDR_W.
- When no write is active, dst_data and dst_addr hold their last value.
- Source and destination must be distinct BRAM instances. In-place operation is not supported.

Decomposition:
- Package point_op_pkg: mode encodings MODE_COPY=0, MODE_ADD=1, MODE_SUB=2, MODE_THRESH=3; FSM state encodings; READ_LATENCY=1 constant.
- Sub-module point_op_alu: combinational f(p, mode, offset, threshold), parameterised by DATA_W. The engine owns the FSM, the counters and the 2-stage valid pipeline.

Test Plan:
- NUM_PIXELS=4, src={10,20,30,40}, mode 0 -> writes on cycles 2..5 to addresses 0..3 with {10,20,30,40}; done on cycle 6; busy high for cycles 0..5.
- mode 1, offset=10, src={0,245,250,255} -> dst={10,255,255,255}.
- mode 2, offset=10, src={5,10,11,200} -> dst={0,0,1,190}.
- mode 3, threshold=128, src={0,127,128,255} -> dst={0,0,255,255}.
- NUM_PIXELS=1 -> one read at address 0 in cycle 0, one write in cycle 2, done in cycle 3. Then a start pulse in cycle 1 and a mode change in cycle 1 -> ignored: no second run, and the result still uses the latched mode.
- NUM_PIXELS=8, reset asserted in cycle 4 -> from the next cycle all outputs are 0, state is IDLE, and no write to address 3 or above occurs. A new start then runs cleanly from address 0.
